// File: rtl/lattice_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lattice_scheduler_pkg                                      |
// | Description : Shared types for the lattice work scheduler: FSM state    |
// |               encoding, job record layout and default widths.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lattice_scheduler_pkg;

  localparam int DEF_NONCE_BITS     = 32;
  localparam int DEF_LOG2_NUM_CORES = 1;
  // Width of the nonce base handed to the lattice; the low nonce bits
  // come from each block's own INDEX.
  localparam int BASE_BITS          = DEF_NONCE_BITS - DEF_LOG2_NUM_CORES;
  localparam int JOB_ID_W           = 2;
  localparam int MIDSTATE_W         = 256;
  localparam int DATA_W             = 96;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA_W-1:0]     data;
    logic [JOB_ID_W-1:0]   id;
  } job_t;

  // Results are only meaningful while the job that produced them is live.
  function automatic logic result_accepted(sched_state_e s);
    return (s == ST_ISSUE) || (s == ST_DRAIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lattice_result_tagger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lattice_result_tagger                                      |
// | Description : Registers results leaving the lattice output chain and    |
// |               tags them with the current job id. Results are dropped    |
// |               unless the scheduler is in ISSUE or DRAIN.                |
// | Ports       : clk, rst (sync, active-low), state_i (scheduler state),   |
// |               job_id_i (tag of live job), res_valid_i/res_nonce_i       |
// |               (raw result), found_valid_o/found_nonce_o/found_id_o      |
// |               (tagged, registered result, 1-cycle pulse).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lattice_result_tagger
  import lattice_scheduler_pkg::*;
#(
  parameter int NONCE_BITS  = DEF_NONCE_BITS,
  parameter int JOB_ID_BITS = JOB_ID_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  sched_state_e           state_i,
  input  logic [JOB_ID_BITS-1:0] job_id_i,
  input  logic                   res_valid_i,
  input  logic [NONCE_BITS-1:0]  res_nonce_i,
  output logic                   found_valid_o,
  output logic [NONCE_BITS-1:0]  found_nonce_o,
  output logic [JOB_ID_BITS-1:0] found_id_o
);

  logic                   found_valid_d, found_valid_q;
  logic [NONCE_BITS-1:0]  found_nonce_d, found_nonce_q;
  logic [JOB_ID_BITS-1:0] found_id_d,    found_id_q;
  logic                   accept;

  always_comb begin
    accept        = res_valid_i && result_accepted(state_i);
    found_valid_d = accept;
    found_nonce_d = found_nonce_q;
    found_id_d    = found_id_q;
    if (accept) begin
      found_nonce_d = res_nonce_i;
      found_id_d    = job_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      found_valid_q <= 1'b0;
      found_nonce_q <= '0;
      found_id_q    <= '0;
    end else begin
      found_valid_q <= found_valid_d;
      found_nonce_q <= found_nonce_d;
      found_id_q    <= found_id_d;
    end
  end

  assign found_valid_o = found_valid_q;
  assign found_nonce_o = found_nonce_q;
  assign found_id_o    = found_id_q;

endmodule
`default_nettype wire

// File: rtl/lattice_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lattice_scheduler                                          |
// | Description : Accepts one job at a time, streams one nonce base per     |
// |               cycle into the lattice, tags returning results, drains    |
// |               the pipeline and signals completion. Supports abort with  |
// |               a flush of in-flight results.                             |
// | Ports       : clk, rst (sync, active-low)                               |
// |               job_*  : valid/ready job intake (midstate, data, id)      |
// |               abort_i: cancel current job                               |
// |               lat_*  : lattice input beat (valid, midstate, data, base) |
// |               res_*  : raw result from lattice output chain             |
// |               found_*: tagged result pulse                              |
// |               job_done_o, busy_o : status                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lattice_scheduler
  import lattice_scheduler_pkg::*;
#(
  parameter int LOG2_NUM_CORES = DEF_LOG2_NUM_CORES,
  parameter int NONCE_BITS     = DEF_NONCE_BITS,
  parameter int DRAIN_CYCLES   = 140,
  parameter int JOB_ID_BITS    = JOB_ID_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [MIDSTATE_W-1:0]              job_midstate_i,
  input  logic [DATA_W-1:0]                  job_data_i,
  input  logic [JOB_ID_BITS-1:0]             job_id_i,
  input  logic                               abort_i,
  output logic                               lat_valid_o,
  output logic [MIDSTATE_W-1:0]              lat_midstate_o,
  output logic [DATA_W-1:0]                  lat_data_o,
  output logic [NONCE_BITS-LOG2_NUM_CORES-1:0] lat_base_o,
  input  logic                               res_valid_i,
  input  logic [NONCE_BITS-1:0]              res_nonce_i,
  output logic                               found_valid_o,
  output logic [NONCE_BITS-1:0]              found_nonce_o,
  output logic [JOB_ID_BITS-1:0]             found_id_o,
  output logic                               job_done_o,
  output logic                               busy_o
);

  localparam int              BASE_W     = NONCE_BITS - LOG2_NUM_CORES;
  localparam int              CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [BASE_W-1:0] BASE_LAST = '1;

  sched_state_e      state_d, state_q;
  logic [BASE_W-1:0] base_d, base_q;
  logic [CNT_W-1:0]  drain_d, drain_q;
  job_t              job_d, job_q;
  logic              lat_valid_d, lat_valid_q;
  logic              job_ready_d, job_ready_q;
  logic              busy_d, busy_q;
  logic              job_done_d, job_done_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    drain_d = drain_q;
    job_d   = job_q;

    unique case (state_q)
      ST_IDLE: begin
        if (job_valid_i && job_ready_q) begin
          job_d   = '{midstate: job_midstate_i,
                      data:     job_data_i,
                      id:       JOB_ID_W'(job_id_i)};
          base_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Abort outranks the natural end of the sweep.
        if (abort_i) begin
          state_d = ST_FLUSH;
          drain_d = DRAIN_LOAD;
        end else if (base_q == BASE_LAST) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          base_d = base_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The zero-count cycle already carries the done pulse, so an abort
        // arriving then is ignored rather than producing a second pulse.
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else if (abort_i) begin
          state_d = ST_FLUSH;
          drain_d = DRAIN_LOAD;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_FLUSH: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next state, so they line
    // up with the cycle in which that state is current.
    lat_valid_d = (state_d == ST_ISSUE);
    job_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    job_done_d  = ((state_d == ST_DRAIN) || (state_d == ST_FLUSH)) && (drain_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      drain_q     <= '0;
      job_q       <= '0;
      lat_valid_q <= 1'b0;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      drain_q     <= drain_d;
      job_q       <= job_d;
      lat_valid_q <= lat_valid_d;
      job_ready_q <= job_ready_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
    end
  end

  lattice_result_tagger #(
    .NONCE_BITS  (NONCE_BITS),
    .JOB_ID_BITS (JOB_ID_BITS)
  ) u_tagger (
    .clk           (clk),
    .rst           (rst),
    .state_i       (state_q),
    .job_id_i      (JOB_ID_BITS'(job_q.id)),
    .res_valid_i   (res_valid_i),
    .res_nonce_i   (res_nonce_i),
    .found_valid_o (found_valid_o),
    .found_nonce_o (found_nonce_o),
    .found_id_o    (found_id_o)
  );

  assign job_ready_o    = job_ready_q;
  assign lat_valid_o    = lat_valid_q;
  assign lat_midstate_o = job_q.midstate;
  assign lat_data_o     = job_q.data;
  assign lat_base_o     = base_q;
  assign job_done_o     = job_done_q;
  assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: doc/lattice_scheduler.md
Name: lattice_scheduler

Overview:
Work-sequencing controller at the head of the mining lattice. It accepts one job (midstate plus header tail) at a time over a valid/ready handshake and streams it into the lattice input pipeline with one nonce base per cycle. Each lattice block expands a base into {base, INDEX}. The scheduler collects "found" results returning from the lattice output chain, tags them with the job ID, drains the pipeline after the last base and signals job completion. It also supports abort/preemption with flush of in-flight results.

Parameters:
LOG2_NUM_CORES, 1, log2 of lattice blocks; low nonce bits come from the block INDEX
NONCE_BITS, 32, total nonce width; reduced in tests to shorten sweeps
DRAIN_CYCLES, 140, cycles from last issued base until its result is guaranteed to have exited the lattice; must be >= 1
JOB_ID_BITS, 2, width of the job tag

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
job_valid_i  in  1  new job offered
job_ready_o  out  1  scheduler can accept a job
job_midstate_i  in  256  SHA-256 midstate of the job
job_data_i  in  96  header tail (merkle tail, time, bits)
job_id_i  in  JOB_ID_BITS  caller tag for the job
abort_i  in  1  cancel the current job
lat_valid_o  out  1  lattice input beat valid
lat_midstate_o  out  256  midstate to lattice
lat_data_o  out  96  header tail to lattice
lat_base_o  out  NONCE_BITS-LOG2_NUM_CORES  nonce base for this beat
res_valid_i  in  1  result exiting lattice output chain
res_nonce_i  in  NONCE_BITS  winning nonce
found_valid_o  out  1  tagged result valid (1-cycle pulse)
found_nonce_o  out  NONCE_BITS  winning nonce
found_id_o  out  JOB_ID_BITS  job tag of the result
job_done_o  out  1  1-cycle pulse: job fully swept and drained, or abort flush finished
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, all counters 0, job_ready_o=1, lat_valid_o=0, found_valid_o=0, job_done_o=0, busy_o=0. The data outputs are held at 0. Reset mid-job discards the job with no done pulse.
- States are IDLE, ISSUE, DRAIN and FLUSH.
- IDLE: job_ready_o=1. On job_valid_i&&job_ready_o, register midstate, data and id; set base=0; go to ISSUE on the next cycle. job_ready_o=0 in every other state.
- ISSUE: lat_valid_o=1 every cycle, with lat_base_o=base and the registered midstate and data. base increments by 1 per cycle. When base==all-ones has been issued, go to DRAIN and load drain_cnt=DRAIN_CYCLES-1. Total beats per job = 2^(NONCE_BITS-LOG2_NUM_CORES). No wrap past all-ones.
- DRAIN: lat_valid_o=0. drain_cnt decrements each cycle. At 0, pulse job_done_o and return to IDLE. The job is accepted again no earlier than the next cycle.
- Results: in ISSUE or DRAIN, res_valid_i produces found_valid_o=1 one cycle later, with found_nonce_o=res_nonce_i and found_id_o set to the current job id. One result per cycle is accepted with no backpressure. Results in IDLE or FLUSH are dropped.
- Results in the done cycle: a result arriving in the same cycle as the DRAIN-to-IDLE transition is still forwarded.
- abort_i in ISSUE or DRAIN: lat_valid_o=0 from the next cycle. Enter FLUSH with drain_cnt=DRAIN_CYCLES-1, counting down while dropping results. At 0, pulse job_done_o and go to IDLE.
- abort_i in IDLE or FLUSH is ignored.
- abort_i has priority over the ISSUE-to-DRAIN transition in the same cycle.
- All outputs are registered. Latency from job handshake to first lat_valid_o is 1 cycle.

Decomposition:
- Shared package holds the state enum, localparam BASE_BITS=NONCE_BITS-LOG2_NUM_CORES, and a job_t struct (midstate, data, id) reused by the lattice drivers.
- One natural sub-module: lattice_result_tagger. It registers res_* into found_* and applies the accept/drop gating from a state input.

Test Plan:
- NONCE_BITS=4, LOG2_NUM_CORES=1, DRAIN_CYCLES=5, job id=2: lat_valid_o high for exactly 8 consecutive cycles with bases 0..7. Then job_done_o pulses exactly 5 cycles after the last beat.
- res_valid_i with nonce 0x9 during ISSUE, and with 0xA on the last DRAIN cycle: found_valid_o pulses twice, carrying 0x9/id 2 and 0xA/id 2, each one cycle after its input.
- job_valid_i held high while busy: job_ready_o=0 and no second job is accepted. The second job is accepted in the first IDLE cycle after done, and its bases restart at 0.
- abort_i at base 3: lat_valid_o low from the next cycle. A res_valid_i during FLUSH produces no found_valid_o. job_done_o pulses after 5 flush cycles.
- abort_i in the same cycle as base 7 is issued: the block enters FLUSH, not DRAIN.
- rst low for 1 cycle mid-ISSUE: all outputs return to reset values, there is no job_done_o, and job_ready_o=1 on the next cycle.
